// File: rtl/dcache_sa_controller.sv
// N-way set-associative write-back, write-allocate data cache controller for the MEM stage.
// Define DCACHE_LRU_EN for true-LRU victim selection; otherwise a per-set round-robin pointer is used.
module dcache_sa_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int WSEL_W = OFF_W - BYTE_W;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WB, REFILL, DONE} state_t;

  state_t            state_q;
  logic [TAG_W-1:0]  tag_mem_q  [SETS][WAYS];
  logic [LINE_W-1:0] data_mem_q [SETS][WAYS];
  logic [WAYS-1:0]   valid_q    [SETS];
  logic [WAYS-1:0]   dirty_q    [SETS];
`ifdef DCACHE_LRU_EN
  logic [WAY_W-1:0]  age_q      [SETS][WAYS];
`else
  logic [WAY_W-1:0]  rr_q       [SETS];
`endif
  logic [WAY_W-1:0]  victim_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  rtag_q;
  logic              mem_enable_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_data_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] word_sel;
  logic              req, is_write, is_load;
  logic              hit, idle_hit, fill, victim_dirty;
  logic [WAY_W-1:0]  hit_way, pol_way, victim_way;
  logic              unused_byte_bits;

  assign req_idx          = cpu_addr_i[OFF_W +: IDX_W];
  assign req_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign word_sel         = cpu_addr_i[BYTE_W +: WSEL_W];
  assign unused_byte_bits = ^cpu_addr_i[BYTE_W-1:0];
  assign req              = cpu_MemRead_i | cpu_MemWrite_i;
  assign is_write         = cpu_MemWrite_i;
  assign is_load          = cpu_MemRead_i & ~cpu_MemWrite_i;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_mem_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    pol_way = '0;
`ifdef DCACHE_LRU_EN
    for (int w = 0; w < WAYS; w++)
      if (age_q[req_idx][w] == WAY_W'(WAYS - 1)) pol_way = WAY_W'(w);
`else
    pol_way = rr_q[req_idx];
`endif
    // Descending scan so the lowest-index invalid way wins.
    victim_way = pol_way;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[req_idx][w]) victim_way = WAY_W'(w);
  end

  assign victim_dirty = valid_q[req_idx][victim_way] & dirty_q[req_idx][victim_way];
  assign idle_hit     = (state_q == IDLE) && req && hit;
  assign fill         = (state_q == REFILL) && mem_ack_i;

  assign cpu_stall_o  = rst_i && ((state_q != IDLE) || (req && !hit));
  assign cpu_data_o   = (rst_i && idle_hit && is_load)
                      ? data_mem_q[req_idx][hit_way][int'(word_sel) * DATA_W +: DATA_W] : '0;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      victim_q     <= '0;
      idx_q        <= '0;
      rtag_q       <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
`ifdef DCACHE_LRU_EN
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
`else
        rr_q[s] <= '0;
`endif
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_hit && is_write) dirty_q[req_idx][hit_way] <= 1'b1;
          if (req && !hit) begin
            victim_q     <= victim_way;
            idx_q        <= req_idx;
            rtag_q       <= req_tag;
            mem_enable_q <= 1'b1;
            if (victim_dirty) begin
              state_q     <= WB;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_mem_q[req_idx][victim_way], req_idx, {OFF_W{1'b0}}};
              mem_data_q  <= data_mem_q[req_idx][victim_way];
            end else begin
              state_q     <= REFILL;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {req_tag, req_idx, {OFF_W{1'b0}}};
            end
          end
        end
        WB: if (mem_ack_i) begin
          state_q     <= REFILL;
          mem_write_q <= 1'b0;
          mem_addr_q  <= {rtag_q, idx_q, {OFF_W{1'b0}}};
        end
        REFILL: if (mem_ack_i) begin
          state_q                 <= DONE;
          mem_enable_q            <= 1'b0;
          valid_q[idx_q][victim_q] <= 1'b1;
          dirty_q[idx_q][victim_q] <= 1'b0;
`ifndef DCACHE_LRU_EN
          rr_q[idx_q] <= (WAYS == 1) ? '0 : rr_q[idx_q] + 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
`ifdef DCACHE_LRU_EN
      if (idle_hit) begin
        for (int w = 0; w < WAYS; w++)
          if (WAY_W'(w) == hit_way) age_q[req_idx][w] <= '0;
          else if (age_q[req_idx][w] < age_q[req_idx][hit_way])
            age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
      end else if (fill) begin
        for (int w = 0; w < WAYS; w++)
          if (WAY_W'(w) == victim_q) age_q[idx_q][w] <= '0;
          else if (age_q[idx_q][w] < age_q[idx_q][victim_q])
            age_q[idx_q][w] <= age_q[idx_q][w] + 1'b1;
      end
`endif
    end
  end

  // NOTE: tag/data storage is deliberately not reset; valid bits alone decide whether it is meaningful.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (fill) begin
        data_mem_q[idx_q][victim_q] <= mem_data_i;
        tag_mem_q[idx_q][victim_q]  <= rtag_q;
      end else if (idle_hit && is_write) begin
        data_mem_q[req_idx][hit_way][int'(word_sel) * DATA_W +: DATA_W] <= cpu_data_i;
      end
    end
  end
endmodule
